snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, maximum number of body segments.
REQ-002 The block SHALL have parameter WIDTH, default 32, board columns.
REQ-003 The block SHALL have parameter HEIGHT, default 24, board rows.
REQ-004 The block SHALL have parameter POS_W, default 10, bits per cell index (index = row*WIDTH + col).
REQ-005 The block SHALL have parameter LEN_W, default 6, bits of the length counter (must hold MAX_LEN).
REQ-006 The block SHALL have parameter INIT_LEN, default 3, length after reset.
REQ-007 The block SHALL have parameter INIT_POS, default 400, head cell after reset; INIT_POS%WIDTH >= INIT_LEN-1.
REQ-008 The block SHALL have parameter WRAP, default 0; 1 = edges wrap, 0 = edge hit kills.
REQ-009 The block SHALL have port clk, input, 1, single system clock, rising edge.
REQ-010 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-011 The block SHALL have port start, input, 1, pulse leaving IDLE.
REQ-012 The block SHALL have port pause, input, 1, level; while high, steps are ignored.
REQ-013 The block SHALL have port step, input, 1, one-cycle move strobe from the rate divider.
REQ-014 The block SHALL have port dir_req, input, 2, requested direction: 00 left, 01 right, 10 up, 11 down.
REQ-015 The block SHALL have port grow, input, 1, food-eaten pulse.
REQ-016 The block SHALL have port body, output, MAX_LEN*POS_W, segment i at bits [i*POS_W +: POS_W]; segment 0 = head.
REQ-017 The block SHALL have port len, output, LEN_W, current valid segment count.
REQ-018 The block SHALL have port state, output, 2, 00 IDLE, 01 RUN, 10 DEAD.
REQ-019 The block SHALL have port moved, output, 1, one-cycle pulse the cycle after a committed move.

Function
REQ-020 The FSM SHALL go IDLE->RUN on start, RUN->DEAD on a fatal step, DEAD->IDLE on start (re-initialising body/len/dir as reset); start in RUN is ignored.
REQ-021 A step SHALL be processed only when state==RUN, pause==0 and step==1; otherwise body, len and dir SHALL hold.
REQ-022 The direction register SHALL load dir_req on each processed step unless dir_req is the exact reverse of the current direction, in which case it keeps the current direction.
REQ-023 Next head SHALL be head-1 / +1 / -WIDTH / +WIDTH for left/right/up/down.
REQ-024 With WRAP=0, moving left at col 0, right at col WIDTH-1, up at row 0 or down at row HEIGHT-1 SHALL be fatal.
REQ-025 With WRAP=1, those moves SHALL wrap to col WIDTH-1, col 0, row HEIGHT-1, row 0 of the same row/column.
REQ-026 A next head equal to any valid segment 0..len-2 SHALL be fatal; when growing this step, segment len-1 also counts.
REQ-027 On a fatal step body, len and dir SHALL hold and state SHALL become DEAD in the same edge.
REQ-028 On a committed move segment i SHALL take segment i-1 (i=1..MAX_LEN-1) and segment 0 the next head, all in one edge; moved pulses the following cycle.
REQ-029 A grow pulse SHALL set a pending flag; the next committed move SHALL increment len by 1 (saturating at MAX_LEN) and clear the flag; grow coincident with a step applies to that step.
REQ-030 Segments at index >= len SHALL be don't-care to consumers but SHALL still shift.

Reset
REQ-031 rst SHALL asynchronously set state=IDLE, dir=right, len=INIT_LEN, pending grow=0, moved=0, segment i = INIT_POS-i for i<INIT_LEN and INIT_POS for the rest.
REQ-032 rst asserted mid-move SHALL override everything; first processed step after release needs start then step.

Structure
REQ-033 Direction codes and state codes SHALL live in shared package snake_pkg.
REQ-034 Next-head and edge/wrap computation SHALL be a combinational sub-module snake_next_pos (parameters WIDTH, HEIGHT, POS_W, WRAP; outputs next_pos, hit_edge).
REQ-035 Self-collision SHALL be a parallel compare of all segments masked by len, no multi-cycle search.

Verification
REQ-036 Reset, start, 3 steps dir_req=01 -> head 403, body[1]=402, len=3, 3 moved pulses.
REQ-037 Head 400 moving right, dir_req=00 then step -> reversal rejected, head 401.
REQ-038 WRAP=0, head col 31, step right -> state=DEAD, head unchanged; WRAP=1 same -> head col 0 same row, RUN.
REQ-039 grow pulse then 2 steps -> len 3->4 on first step only; with len=MAX_LEN further grow keeps len=32.
REQ-040 len=5 driven into a U-turn onto own segment 3 -> DEAD; moving into current tail cell without grow -> survives.
REQ-041 rst asserted between step and moved -> IDLE, initial body, moved=0; pause=1 with steps -> no change.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction and state encodings for the snake engine.
// Also holds the reversal test used by the direction register.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_UP    = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   // Opposite directions differ only in bit 0 within the same axis.
   function automatic logic is_reverse(input dir_t cur, input dir_t req);
      return req == dir_t'({cur[1], ~cur[0]});
   endfunction

endpackage

// File: rtl/snake_engine_if.sv
// Control and observation bundle between the game controller and the engine.
// The controller drives the master side; the engine implements the slave side.
interface snake_engine_if #(
   parameter int MAX_LEN = 32,
   parameter int POS_W   = 10,
   parameter int LEN_W   = 6
);
   logic                     start;
   logic                     pause;
   logic                     step;
   logic [1:0]               dir_req;
   logic                     grow;
   logic [MAX_LEN*POS_W-1:0] body;
   logic [LEN_W-1:0]         len;
   logic [1:0]               state;
   logic                     moved;

   modport master (
      output start, pause, step, dir_req, grow,
      input  body, len, state, moved
   );

   modport slave (
      input  start, pause, step, dir_req, grow,
      output body, len, state, moved
   );
endinterface

// File: rtl/snake_next_pos.sv
// Combinational next-head calculation with board-edge detection.
// With WRAP set the head re-enters on the opposite edge of the same row/column.
module snake_next_pos
   import snake_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 24,
   parameter int POS_W  = 10,
   parameter int WRAP   = 0
) (
   input  logic [POS_W-1:0] head,
   input  dir_t             dir,
   output logic [POS_W-1:0] next_pos,
   output logic             hit_edge
);
   localparam logic [POS_W-1:0] STEP_X = POS_W'(1);
   localparam logic [POS_W-1:0] STEP_Y = POS_W'(WIDTH);
   localparam logic [POS_W-1:0] SPAN_X = POS_W'(WIDTH - 1);
   localparam logic [POS_W-1:0] SPAN_Y = POS_W'((HEIGHT - 1) * WIDTH);

   logic [31:0] col;
   logic [31:0] row;
   logic        at_edge;

   assign col = 32'(head) % WIDTH;
   assign row = 32'(head) / WIDTH;

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      at_edge  = 1'b0;
      next_pos = head;
      case (dir)
         DIR_LEFT: begin
            at_edge  = (col == 0);
            next_pos = at_edge ? head + SPAN_X : head - STEP_X;
         end
         DIR_RIGHT: begin
            at_edge  = (col == 32'(WIDTH - 1));
            next_pos = at_edge ? head - SPAN_X : head + STEP_X;
         end
         DIR_UP: begin
            at_edge  = (row == 0);
            next_pos = at_edge ? head + SPAN_Y : head - STEP_Y;
         end
         default: begin
            at_edge  = (row == 32'(HEIGHT - 1));
            next_pos = at_edge ? head - SPAN_Y : head + STEP_Y;
         end
      endcase
      hit_edge = at_edge && (WRAP == 0);
   end

endmodule

// File: rtl/snake_engine.sv
// Snake body shift register, direction/length tracking and game FSM.
// One processed step either commits a whole-body shift or kills the snake.
module snake_engine
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 32,
   parameter int WIDTH    = 32,
   parameter int HEIGHT   = 24,
   parameter int POS_W    = 10,
   parameter int LEN_W    = 6,
   parameter int INIT_LEN = 3,
   parameter int INIT_POS = 400,
   parameter int WRAP     = 0
) (
   input logic           clk,
   input logic           rst,
   snake_engine_if.slave bus
);
   state_t                   state_q, state_d;
   dir_t                     dir_q, dir_d, dir_eff;
   logic [LEN_W-1:0]         len_q, len_d;
   logic                     grow_pend_q, grow_pend_d;
   logic                     moved_q, moved_d;
   logic [POS_W-1:0]         body_q [MAX_LEN];
   logic [POS_W-1:0]         body_d [MAX_LEN];
   logic [MAX_LEN*POS_W-1:0] body_flat;

   logic             step_ok, growing, self_hit, fatal, commit, reinit;
   logic [POS_W-1:0] next_pos;
   logic             hit_edge;

   function automatic logic [POS_W-1:0] init_seg(input int i);
      return (i < INIT_LEN) ? POS_W'(INIT_POS - i) : POS_W'(INIT_POS);
   endfunction

   snake_next_pos #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .POS_W (POS_W),
      .WRAP  (WRAP)
   ) u_next_pos (
      .head    (body_q[0]),
      .dir     (dir_eff),
      .next_pos(next_pos),
      .hit_edge(hit_edge)
   );

   always_comb begin
      step_ok = (state_q == ST_RUN) && !bus.pause && bus.step;
      dir_eff = is_reverse(dir_q, dir_t'(bus.dir_req)) ? dir_q : dir_t'(bus.dir_req);
      growing = grow_pend_q | bus.grow;
   end

   // The tail cell vacates on this move unless the snake is growing.
   always_comb begin
      self_hit = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((body_q[i] == next_pos) &&
             ((i + 1 < int'(len_q)) || (growing && (i + 1 == int'(len_q)))))
            self_hit = 1'b1;
      end
   end

   assign fatal  = hit_edge | self_hit;
   assign commit = step_ok & ~fatal;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start)        state_d = ST_RUN;
         ST_RUN:  if (step_ok && fatal) state_d = ST_DEAD;
         ST_DEAD: if (bus.start)        state_d = ST_IDLE;
         default:                       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      reinit    = (state_q == ST_DEAD) && bus.start;
      bus.state = state_q;
   end

   always_comb begin
      dir_d       = dir_q;
      len_d       = len_q;
      body_d      = body_q;
      moved_d     = commit;
      grow_pend_d = grow_pend_q | bus.grow;
      if (reinit) begin
         dir_d       = DIR_RIGHT;
         len_d       = LEN_W'(INIT_LEN);
         grow_pend_d = 1'b0;
         for (int i = 0; i < MAX_LEN; i++) body_d[i] = init_seg(i);
      end else if (commit) begin
         dir_d     = dir_eff;
         body_d[0] = next_pos;
         for (int i = 1; i < MAX_LEN; i++) body_d[i] = body_q[i-1];
         if (growing && (len_q != LEN_W'(MAX_LEN))) len_d = len_q + LEN_W'(1);
         grow_pend_d = 1'b0;
      end
   end

   // NOTE: the body array is reset because the first move after start reads it as live state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q       <= DIR_RIGHT;
         len_q       <= LEN_W'(INIT_LEN);
         grow_pend_q <= 1'b0;
         moved_q     <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) body_q[i] <= init_seg(i);
      end else begin
         dir_q       <= dir_d;
         len_q       <= len_d;
         grow_pend_q <= grow_pend_d;
         moved_q     <= moved_d;
         body_q      <= body_d;
      end
   end

   always_comb begin
      body_flat = '0;
      for (int i = 0; i < MAX_LEN; i++) body_flat[i*POS_W +: POS_W] = body_q[i];
   end

   assign bus.body  = body_flat;
   assign bus.len   = len_q;
   assign bus.moved = moved_q;

endmodule
